// File: rtl/udma_cfg_trans_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : udma_cfg_trans_arbiter
//  Description : Round-robin arbiter that collects one pending transfer
//                request per channel and issues them, one at a time, to the
//                uDMA side of a HyperBus controller.  Each issued
//                transaction is held until the HyperBus side reports
//                completion, after which the owning channel gets a
//                completion pulse.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i                   clock
//    rst_ni                  asynchronous active-low reset
//    req_valid_i  [NB_CH]    per-channel request valid
//    req_ready_o  [NB_CH]    per-channel request ready (buffer empty)
//    req_addr_i              per-channel L2 start address, channel i in slice i
//    req_size_i              per-channel byte count, channel i in slice i
//    req_rw_i     [NB_CH]    per-channel direction, 1 = hyper read (rx)
//    trans_done_i            one-cycle pulse: current transaction finished
//    toudma_tx_start_addr_o  tx start address of the issued transaction
//    toudma_tx_size_o        tx size of the issued transaction
//    toudma_rx_start_addr_o  rx start address of the issued transaction
//    toudma_rx_size_o        rx size of the issued transaction
//    toudma_rw_hyper_o       direction of the issued transaction
//    toudma_trans_valid_o    one-cycle issue strobe
//    toudma_trans_id_o       granted channel, 1<<ID_WIDTH when idle
//    evt_done_o   [NB_CH]    per-channel completion pulse
// ============================================================================
module udma_cfg_trans_arbiter #(
    parameter int L2_AWIDTH_NOAL = 12,
    parameter int TRANS_SIZE     = 16,
    parameter int NB_CH          = 2,
    parameter int ID_WIDTH       = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,

    input  logic [NB_CH-1:0]                req_valid_i,
    output logic [NB_CH-1:0]                req_ready_o,
    input  logic [NB_CH*L2_AWIDTH_NOAL-1:0] req_addr_i,
    input  logic [NB_CH*TRANS_SIZE-1:0]     req_size_i,
    input  logic [NB_CH-1:0]                req_rw_i,

    input  logic                            trans_done_i,

    output logic [L2_AWIDTH_NOAL-1:0]       toudma_tx_start_addr_o,
    output logic [TRANS_SIZE-1:0]           toudma_tx_size_o,
    output logic [L2_AWIDTH_NOAL-1:0]       toudma_rx_start_addr_o,
    output logic [TRANS_SIZE-1:0]           toudma_rx_size_o,
    output logic                            toudma_rw_hyper_o,
    output logic                            toudma_trans_valid_o,
    output logic [ID_WIDTH:0]               toudma_trans_id_o,

    output logic [NB_CH-1:0]                evt_done_o
);

    // Idle value of the ID bus: the extra MSB marks "no channel granted".
    localparam logic [ID_WIDTH:0] ID_IDLE = {1'b1, {ID_WIDTH{1'b0}}};
    localparam logic [ID_WIDTH:0] NB_CH_W = (ID_WIDTH+1)'(NB_CH);
    localparam logic [ID_WIDTH-1:0] LAST_CH = ID_WIDTH'(NB_CH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Per-channel request slices.
    logic [L2_AWIDTH_NOAL-1:0] ch_addr [NB_CH];
    logic [TRANS_SIZE-1:0]     ch_size [NB_CH];

    // One-entry pending buffer per channel.
    logic [NB_CH-1:0]          pending;
    logic [L2_AWIDTH_NOAL-1:0] buf_addr [NB_CH];
    logic [TRANS_SIZE-1:0]     buf_size [NB_CH];
    logic [NB_CH-1:0]          buf_rw;

    logic [NB_CH-1:0]          accept;
    logic [NB_CH-1:0]          zero_size;
    logic [NB_CH-1:0]          clear;
    logic [NB_CH-1:0]          evt_done;

    logic [ID_WIDTH-1:0]       rr_ptr;
    logic [ID_WIDTH-1:0]       winner;
    logic [ID_WIDTH:0]         cand;
    logic                      found;
    logic                      any_pending;
    logic                      issue_load;
    logic                      done_fire;
    logic [ID_WIDTH:0]         trans_id;

    // ------------------------------------------------------------------
    // Request bus slicing
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NB_CH; i++) begin : g_slice
        assign ch_addr[i] = req_addr_i[i*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL];
        assign ch_size[i] = req_size_i[i*TRANS_SIZE +: TRANS_SIZE];
    end

    assign done_fire   = (state_q == ST_WAIT) & trans_done_i;
    assign any_pending = |pending;
    assign issue_load  = (state_q == ST_IDLE) & any_pending;

    // Handshake, zero-size detect and completion decode per channel.
    // A channel being completed still reads as busy on the done edge, so a
    // simultaneous new valid is only taken on the following edge.
    always_comb begin
        accept    = '0;
        zero_size = '0;
        clear     = '0;
        for (int i = 0; i < NB_CH; i++) begin
            accept[i]    = req_valid_i[i] & ~pending[i];
            zero_size[i] = (ch_size[i] == '0);
            clear[i]     = done_fire & (trans_id == (ID_WIDTH+1)'(i));
        end
    end

    // ------------------------------------------------------------------
    // Pending buffers and completion events
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending  <= '0;
            buf_rw   <= '0;
            evt_done <= '0;
            for (int i = 0; i < NB_CH; i++) begin
                buf_addr[i] <= '0;
                buf_size[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_CH; i++) begin
                // Zero-byte requests complete immediately without an issue.
                evt_done[i] <= (accept[i] & zero_size[i]) | clear[i];
                if (clear[i]) begin
                    pending[i] <= 1'b0;
                end else if (accept[i] & ~zero_size[i]) begin
                    pending[i]  <= 1'b1;
                    buf_addr[i] <= ch_addr[i];
                    buf_size[i] <= ch_size[i];
                    buf_rw[i]   <= req_rw_i[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin winner search starting at rr_ptr.  The candidate index
    // is kept one bit wider so the modulo wrap works for any NB_CH, and
    // indices >= NB_CH are never produced.
    // ------------------------------------------------------------------
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NB_CH; k++) begin
            cand = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
            if (cand >= NB_CH_W) begin
                cand = cand - NB_CH_W;
            end
            if (!found && pending[cand[ID_WIDTH-1:0]]) begin
                found  = 1'b1;
                winner = cand[ID_WIDTH-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pending) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (trans_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Issue registers.  Address, size and direction keep their last values
    // between transactions; only the ID returns to its idle code.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            toudma_tx_start_addr_o <= '0;
            toudma_tx_size_o       <= '0;
            toudma_rx_start_addr_o <= '0;
            toudma_rx_size_o       <= '0;
            toudma_rw_hyper_o      <= 1'b0;
            trans_id               <= ID_IDLE;
            rr_ptr                 <= '0;
        end else if (issue_load) begin
            trans_id <= {1'b0, winner};
            rr_ptr   <= (winner == LAST_CH) ? '0 : winner + ID_WIDTH'(1);
            if (buf_rw[winner]) begin
                toudma_rx_start_addr_o <= buf_addr[winner];
                toudma_rx_size_o       <= buf_size[winner];
                toudma_tx_start_addr_o <= '0;
                toudma_tx_size_o       <= '0;
                toudma_rw_hyper_o      <= 1'b1;
            end else begin
                toudma_tx_start_addr_o <= buf_addr[winner];
                toudma_tx_size_o       <= buf_size[winner];
                toudma_rx_start_addr_o <= '0;
                toudma_rx_size_o       <= '0;
                toudma_rw_hyper_o      <= 1'b0;
            end
        end else if (done_fire) begin
            trans_id <= ID_IDLE;
        end
    end

    assign req_ready_o          = ~pending;
    assign toudma_trans_valid_o = (state_q == ST_ISSUE);
    assign toudma_trans_id_o    = trans_id;
    assign evt_done_o           = evt_done;

endmodule
`default_nettype wire

// File: tb/tb_udma_cfg_trans_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_udma_cfg_trans_arbiter
//  Description : Scoreboard bench for udma_cfg_trans_arbiter.  Directed
//                stimulus pushes expected issues and completion events into
//                queues; a monitor pops and compares whenever the DUT
//                strobes an issue or a completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_udma_cfg_trans_arbiter;

    localparam int AW  = 12;
    localparam int SW  = 16;
    localparam int NB  = 2;
    localparam int IDW = 1;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic [NB-1:0]    req_valid_i;
    logic [NB-1:0]    req_ready_o;
    logic [NB*AW-1:0] req_addr_i;
    logic [NB*SW-1:0] req_size_i;
    logic [NB-1:0]    req_rw_i;
    logic             trans_done_i;
    logic [AW-1:0]    toudma_tx_start_addr_o;
    logic [SW-1:0]    toudma_tx_size_o;
    logic [AW-1:0]    toudma_rx_start_addr_o;
    logic [SW-1:0]    toudma_rx_size_o;
    logic             toudma_rw_hyper_o;
    logic             toudma_trans_valid_o;
    logic [IDW:0]     toudma_trans_id_o;
    logic [NB-1:0]    evt_done_o;

    udma_cfg_trans_arbiter #(
        .L2_AWIDTH_NOAL (AW),
        .TRANS_SIZE     (SW),
        .NB_CH          (NB),
        .ID_WIDTH       (IDW)
    ) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_addr_i             (req_addr_i),
        .req_size_i             (req_size_i),
        .req_rw_i               (req_rw_i),
        .trans_done_i           (trans_done_i),
        .toudma_tx_start_addr_o (toudma_tx_start_addr_o),
        .toudma_tx_size_o       (toudma_tx_size_o),
        .toudma_rx_start_addr_o (toudma_rx_start_addr_o),
        .toudma_rx_size_o       (toudma_rx_size_o),
        .toudma_rw_hyper_o      (toudma_rw_hyper_o),
        .toudma_trans_valid_o   (toudma_trans_valid_o),
        .toudma_trans_id_o      (toudma_trans_id_o),
        .evt_done_o             (evt_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [AW-1:0] tx_addr;
        logic [SW-1:0] tx_size;
        logic [AW-1:0] rx_addr;
        logic [SW-1:0] rx_size;
        logic          rw;
        logic [IDW:0]  id;
    } txn_t;

    txn_t          exp_q[$];
    logic [NB-1:0] done_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compares issues and completion pulses against the queues.
    // ------------------------------------------------------------------
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            if (toudma_trans_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 32'(toudma_trans_valid_o), 32'd0);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    chk("issue_tx_addr", 32'(toudma_tx_start_addr_o), 32'(e.tx_addr));
                    chk("issue_tx_size", 32'(toudma_tx_size_o),       32'(e.tx_size));
                    chk("issue_rx_addr", 32'(toudma_rx_start_addr_o), 32'(e.rx_addr));
                    chk("issue_rx_size", 32'(toudma_rx_size_o),       32'(e.rx_size));
                    chk("issue_rw",      32'(toudma_rw_hyper_o),      32'(e.rw));
                    chk("issue_id",      32'(toudma_trans_id_o),      32'(e.id));
                end
            end
            if (evt_done_o != '0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_evt_done", 32'(evt_done_o), 32'd0);
                end else begin
                    chk("evt_done", 32'(evt_done_o), 32'(done_q.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk_i);
    endtask

    function automatic txn_t make_txn(input int ch, input logic [AW-1:0] a,
                                      input logic [SW-1:0] s, input logic rw);
        txn_t t;
        t.tx_addr = rw ? '0 : a;
        t.tx_size = rw ? '0 : s;
        t.rx_addr = rw ? a : '0;
        t.rx_size = rw ? s : '0;
        t.rw      = rw;
        t.id      = (IDW+1)'(ch);
        return t;
    endfunction

    task automatic push_req(input int ch, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic rw);
        req_valid_i[ch]          = 1'b1;
        req_addr_i[ch*AW +: AW]  = a;
        req_size_i[ch*SW +: SW]  = s;
        req_rw_i[ch]             = rw;
        if (s != '0) exp_q.push_back(make_txn(ch, a, s, rw));
    endtask

    task automatic clr_req();
        req_valid_i = '0;
    endtask

    task automatic pulse_done(input int ch);
        trans_done_i = 1'b1;
        done_q.push_back(NB'(1 << ch));
        step();
        trans_done_i = 1'b0;
    endtask

    task automatic wait_issue(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            if (toudma_trans_valid_o) seen = 1'b1;
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s: got no issue expected issue within 20 cycles", name);
        end
        checks++;
    endtask

    task automatic run_txn(input string name, input int ch);
        wait_issue(name);
        step();
        pulse_done(ch);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o),            32'h3);
        chk({tag, "_id"},    32'(toudma_trans_id_o),      32'h2);
        chk({tag, "_valid"}, 32'(toudma_trans_valid_o),   32'h0);
        chk({tag, "_evt"},   32'(evt_done_o),             32'h0);
        chk({tag, "_txa"},   32'(toudma_tx_start_addr_o), 32'h0);
        chk({tag, "_txs"},   32'(toudma_tx_size_o),       32'h0);
        chk({tag, "_rxa"},   32'(toudma_rx_start_addr_o), 32'h0);
        chk({tag, "_rxs"},   32'(toudma_rx_size_o),       32'h0);
        chk({tag, "_rw"},    32'(toudma_rw_hyper_o),      32'h0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        req_valid_i  = '0;
        req_addr_i   = '0;
        req_size_i   = '0;
        req_rw_i     = '0;
        trans_done_i = 1'b0;
        rst_ni       = 1'b0;
        step();
        step();
        chk_reset("reset");
        rst_ni = 1'b1;
        step();

        // Single read on ch0.
        push_req(0, 12'h100, 16'd64, 1'b1);
        step();
        clr_req();
        chk("s1_ready0_low", 32'(req_ready_o[0]), 32'd0);
        chk("s1_idle_gap",   32'(toudma_trans_valid_o), 32'd0);
        step();
        chk("s1_issue",      32'(toudma_trans_valid_o), 32'd1);
        step();
        chk("s1_valid_1cyc", 32'(toudma_trans_valid_o), 32'd0);
        chk("s1_id_wait",    32'(toudma_trans_id_o), 32'd0);
        pulse_done(0);
        chk("s1_id_idle",    32'(toudma_trans_id_o), 32'd2);
        chk("s1_hold_rxa",   32'(toudma_rx_start_addr_o), 32'h100);
        chk("s1_hold_rw",    32'(toudma_rw_hyper_o), 32'd1);
        chk("s1_ready_back", 32'(req_ready_o[0]), 32'd1);
        step();
        chk("s1_evt_1cyc",   32'(evt_done_o), 32'd0);

        // Simultaneous ch0 write / ch1 read from reset, then a second round.
        do_reset();
        push_req(0, 12'h200, 16'd16, 1'b0);
        push_req(1, 12'h300, 16'd32, 1'b1);
        step();
        clr_req();
        run_txn("s2_a", 0);
        chk("s2_gap_idle",   32'(toudma_trans_valid_o), 32'd0);
        step();
        chk("s2_b_issue",    32'(toudma_trans_valid_o), 32'd1);
        step();
        pulse_done(1);
        push_req(0, 12'h210, 16'd4, 1'b1);
        push_req(1, 12'h310, 16'd8, 1'b0);
        step();
        clr_req();
        run_txn("s2_c", 0);
        run_txn("s2_d", 1);

        // Size-0 request on ch1.
        step();
        push_req(1, 12'h050, 16'd0, 1'b1);
        done_q.push_back(2'b10);
        step();
        clr_req();
        chk("s3_ready1", 32'(req_ready_o[1]), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s3_no_issue", 32'(toudma_trans_valid_o), 32'd0);
            chk("s3_ready1_hold", 32'(req_ready_o[1]), 32'd1);
        end

        // trans_done_i in IDLE (nothing pending), then across IDLE and ISSUE.
        trans_done_i = 1'b1;
        step();
        trans_done_i = 1'b0;
        chk("s4_idle_ready", 32'(req_ready_o), 32'h3);
        push_req(0, 12'h120, 16'd20, 1'b1);
        step();
        clr_req();
        trans_done_i = 1'b1;
        step();
        chk("s4_issue",      32'(toudma_trans_valid_o), 32'd1);
        step();
        trans_done_i = 1'b0;
        chk("s4_wait_valid", 32'(toudma_trans_valid_o), 32'd0);
        chk("s4_wait_id",    32'(toudma_trans_id_o), 32'd0);
        chk("s4_pending",    32'(req_ready_o[0]), 32'd0);
        step();
        chk("s4_still_wait", 32'(toudma_trans_id_o), 32'd0);
        pulse_done(0);

        // Back-to-back ch0 with valid held high.
        push_req(0, 12'h400, 16'd8, 1'b0);
        step();
        chk("s5_ready_low",  32'(req_ready_o[0]), 32'd0);
        push_req(0, 12'h500, 16'd12, 1'b1);
        wait_issue("s5_a");
        step();
        chk("s5_ready_wait", 32'(req_ready_o[0]), 32'd0);
        pulse_done(0);
        chk("s5_ready_after_done", 32'(req_ready_o[0]), 32'd1);
        step();
        clr_req();
        chk("s5_b_accepted", 32'(req_ready_o[0]), 32'd0);
        chk("s5_b_gap",      32'(toudma_trans_valid_o), 32'd0);
        step();
        chk("s5_b_issue",    32'(toudma_trans_valid_o), 32'd1);
        step();
        pulse_done(0);

        // Reset asserted in WAIT.
        push_req(1, 12'h3F0, 16'd100, 1'b0);
        step();
        clr_req();
        wait_issue("s6_a");
        step();
        rst_ni = 1'b0;
        #1;
        chk_reset("s6_rst");
        step();
        rst_ni = 1'b1;
        step();
        chk("s6_ready_after", 32'(req_ready_o), 32'h3);
        push_req(0, 12'h0AA, 16'd2, 1'b1);
        step();
        clr_req();
        run_txn("s6_b", 0);

        step();
        step();
        chk("end_exp_q_empty",  32'(exp_q.size()),  32'd0);
        chk("end_done_q_empty", 32'(done_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
